ex_alu_stage: RTL and testbench

EX_ALU_STAGE -- requirements
Module: ex_alu_stage

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_core.sv | 54 +++++
 rtl/ex_alu_stage.sv | 126 ++++++++++++
 tb/tb_ex_alu_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ALU control codes and EX skid-stage state encoding.
// Shared with the ALU-control decoder.
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_ILL = 4'b1111;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } ex_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: AND/OR/ADD/SUB, zero and illegal flags.
// EX_ALU_OVF_EN adds a signed-overflow flag for ADD/SUB.
module alu_core
   import alu_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [3:0]        alu_ctrl,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
`ifdef EX_ALU_OVF_EN
   output logic              ovf,
`endif
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              illegal
);

   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] diff;

   assign sum  = op_a + op_b;
   assign diff = op_a - op_b;

   always_comb begin
      result  = '0;
      illegal = 1'b0;
      unique case (alu_ctrl)
         ALU_AND: result = op_a & op_b;
         ALU_OR:  result = op_a | op_b;
         ALU_ADD: result = sum;
         ALU_SUB: result = diff;
         default: illegal = 1'b1;
      endcase
   end

   assign zero = (result == '0);

`ifdef EX_ALU_OVF_EN
   logic sa;
   logic sb;
   assign sa = op_a[DATA_W-1];
   assign sb = op_b[DATA_W-1];

   always_comb begin
      ovf = 1'b0;
      if (alu_ctrl == ALU_ADD)
         ovf = (sa == sb) && (sum[DATA_W-1] != sa);
      else if (alu_ctrl == ALU_SUB)
         ovf = (sa != sb) && (diff[DATA_W-1] != sa);
   end
`endif

endmodule

// File: rtl/ex_alu_stage.sv
// EX stage: registered ALU result behind a two-entry skid buffer.
// Define EX_ALU_OVF_EN to add the registered signed-overflow output ovf.
module ex_alu_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int RD_W   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        alu_ctrl,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic [RD_W-1:0]   rd_in,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              illegal,
`ifdef EX_ALU_OVF_EN
   output logic              ovf,
`endif
   output logic [RD_W-1:0]   rd_out
);

`ifdef EX_ALU_OVF_EN
   localparam int OVF_W = 1;
`else
   localparam int OVF_W = 0;
`endif
   localparam int PW = DATA_W + RD_W + 2 + OVF_W;

   logic [DATA_W-1:0] c_res;
   logic              c_zero;
   logic              c_ill;
   logic [PW-1:0]     new_pk;

   ex_state_e     state_q, state_d;
   logic [PW-1:0] out_q, out_d;
   logic [PW-1:0] skid_q, skid_d;
   logic          acc;
   logic          drain;

`ifdef EX_ALU_OVF_EN
   logic c_ovf;
`endif

   alu_core #(.DATA_W(DATA_W)) u_core (
      .alu_ctrl (alu_ctrl),
      .op_a     (op_a),
      .op_b     (op_b),
`ifdef EX_ALU_OVF_EN
      .ovf      (c_ovf),
`endif
      .result   (c_res),
      .zero     (c_zero),
      .illegal  (c_ill)
   );

`ifdef EX_ALU_OVF_EN
   assign new_pk = {c_ovf, c_ill, c_zero, rd_in, c_res};
   assign ovf    = out_q[PW-1];
`else
   assign new_pk = {c_ill, c_zero, rd_in, c_res};
`endif

   // Handshake flags decode straight from the state flop.
   assign in_ready  = (state_q != ST_TWO);
   assign out_valid = (state_q != ST_EMPTY);
   assign acc       = in_valid && in_ready;
   assign drain     = out_valid && out_ready;

   assign result  = out_q[DATA_W-1:0];
   assign rd_out  = out_q[DATA_W +: RD_W];
   assign zero    = out_q[DATA_W+RD_W];
   assign illegal = out_q[DATA_W+RD_W+1];

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      unique case (state_q)
         ST_EMPTY: begin
            if (acc) begin
               out_d   = new_pk;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (acc && drain) begin
               out_d = new_pk;
            end else if (acc) begin
               skid_d  = new_pk;
               state_d = ST_TWO;
            end else if (drain) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (drain) begin
               out_d   = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush)
         state_d = ST_EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         out_q   <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed bench for ex_alu_stage: ALU ops, skid stall, flush, reset.
// Covers ovf when EX_ALU_OVF_EN is defined.
module tb_ex_alu_stage;
   import alu_pkg::*;

   localparam int DW = 64;
   localparam int RW = 5;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    alu_ctrl;
   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;
   logic [RW-1:0] rd_in;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] result;
   logic          zero;
   logic          illegal;
   logic [RW-1:0] rd_out;
`ifdef EX_ALU_OVF_EN
   logic          ovf;
`endif

   int checks = 0;
   int errors = 0;

   ex_alu_stage #(.DATA_W(DW), .RD_W(RW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .op_a      (op_a),
      .op_b      (op_b),
      .rd_in     (rd_in),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal),
`ifdef EX_ALU_OVF_EN
      .ovf       (ovf),
`endif
      .rd_out    (rd_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] c, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [RW-1:0] r);
      in_valid = 1'b1;
      alu_ctrl = c;
      op_a     = a;
      op_b     = b;
      rd_in    = r;
   endtask

   initial begin
      in_valid  = 1'b0;
      alu_ctrl  = ALU_AND;
      op_a      = '0;
      op_b      = '0;
      rd_in     = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      rst_n     = 1'b1;
      #2 rst_n  = 1'b0;
      #1;
      chk("rst_ovalid", {63'd0, out_valid}, 64'd0);
      chk("rst_irdy", {63'd0, in_ready}, 64'd1);
      chk("rst_result", result, 64'd0);
      chk("rst_zero", {63'd0, zero}, 64'd0);
      chk("rst_ill", {63'd0, illegal}, 64'd0);
      chk("rst_rd", {59'd0, rd_out}, 64'd0);
`ifdef EX_ALU_OVF_EN
      chk("rst_ovf", {63'd0, ovf}, 64'd0);
`endif
      step();
      step();
      rst_n = 1'b1;

      drive(ALU_ADD, 64'd5, 64'd7, 5'd3);
      step();
      in_valid = 1'b0;
      chk("add_valid", {63'd0, out_valid}, 64'd1);
      chk("add_res", result, 64'd12);
      chk("add_zero", {63'd0, zero}, 64'd0);
      chk("add_ill", {63'd0, illegal}, 64'd0);
      chk("add_rd", {59'd0, rd_out}, 64'd3);

      drive(ALU_SUB, 64'd9, 64'd9, 5'd4);
      step();
      drive(ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd5);
      chk("sub_res", result, 64'd0);
      chk("sub_zero", {63'd0, zero}, 64'd1);
      chk("sub_rd", {59'd0, rd_out}, 64'd4);
      step();
      in_valid = 1'b0;
      chk("wrap_res", result, 64'd0);
      chk("wrap_zero", {63'd0, zero}, 64'd1);
      chk("wrap_rd", {59'd0, rd_out}, 64'd5);

      drive(ALU_AND, 64'hF0, 64'h3C, 5'd6);
      step();
      drive(ALU_OR, 64'hF0, 64'h3C, 5'd7);
      chk("and_res", result, 64'h30);
      step();
      in_valid = 1'b0;
      chk("or_res", result, 64'hFC);

      drive(4'b1111, 64'd3, 64'd4, 5'd9);
      step();
      in_valid = 1'b0;
      chk("ill_valid", {63'd0, out_valid}, 64'd1);
      chk("ill_res", result, 64'd0);
      chk("ill_flag", {63'd0, illegal}, 64'd1);
      chk("ill_rd", {59'd0, rd_out}, 64'd9);
      step();
      chk("idle_valid", {63'd0, out_valid}, 64'd0);

      // Three back-to-back ops against a stalled consumer.
      out_ready = 1'b0;
      drive(ALU_ADD, 64'd1, 64'd1, 5'd1);
      step();
      drive(ALU_ADD, 64'd2, 64'd2, 5'd2);
      step();
      chk("stall_irdy", {63'd0, in_ready}, 64'd0);
      drive(ALU_ADD, 64'd3, 64'd3, 5'd3);
      step();
      chk("hold_irdy", {63'd0, in_ready}, 64'd0);
      chk("hold_res", result, 64'd2);
      chk("hold_rd", {59'd0, rd_out}, 64'd1);
      out_ready = 1'b1;
      chk("rel1_res", result, 64'd2);
      step();
      chk("rel2_res", result, 64'd4);
      chk("rel2_rd", {59'd0, rd_out}, 64'd2);
      chk("rel2_irdy", {63'd0, in_ready}, 64'd1);
      step();
      in_valid = 1'b0;
      chk("rel3_res", result, 64'd6);
      chk("rel3_rd", {59'd0, rd_out}, 64'd3);
      chk("rel3_valid", {63'd0, out_valid}, 64'd1);
      step();
      chk("rel_empty", {63'd0, out_valid}, 64'd0);

      out_ready = 1'b0;
      drive(ALU_ADD, 64'd10, 64'd0, 5'd7);
      step();
      drive(ALU_ADD, 64'd11, 64'd0, 5'd8);
      step();
      drive(ALU_ADD, 64'd12, 64'd0, 5'd9);
      flush = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_valid", {63'd0, out_valid}, 64'd0);
      chk("fl_irdy", {63'd0, in_ready}, 64'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("fl_quiet", {63'd0, out_valid}, 64'd0);
      end

      // Reset mid-stream discards the held op.
      out_ready = 1'b0;
      drive(ALU_OR, 64'd5, 64'd2, 5'd2);
      step();
      in_valid = 1'b0;
      chk("mr_pre", {63'd0, out_valid}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_valid", {63'd0, out_valid}, 64'd0);
      chk("mr_res", result, 64'd0);
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      drive(ALU_SUB, 64'd20, 64'd5, 5'd11);
      step();
      in_valid = 1'b0;
      chk("mr_first", result, 64'd15);
      chk("mr_rd", {59'd0, rd_out}, 64'd11);

`ifdef EX_ALU_OVF_EN
      drive(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd1);
      step();
      drive(ALU_ADD, 64'd1, 64'd1, 5'd2);
      chk("ovf_flag", {63'd0, ovf}, 64'd1);
      chk("ovf_res", result, 64'h8000_0000_0000_0000);
      step();
      drive(ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 5'd3);
      chk("noovf_flag", {63'd0, ovf}, 64'd0);
      step();
      in_valid = 1'b0;
      chk("subovf_flag", {63'd0, ovf}, 64'd1);
      chk("subovf_res", result, 64'h7FFF_FFFF_FFFF_FFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
